link_eye_scanner: RTL
=====================

LINK_EYE_SCANNER -- requirements
Module: link_eye_scanner

Interface
REQ-001 SHALL have parameter NLINKS, default 12: number of scanned links.
REQ-002 SHALL have parameter DELAY_WIDTH, default 9: delay tap width; taps 0..2^DELAY_WIDTH-1.
REQ-003 SHALL have parameter DWELL_WIDTH, default 16: width of the dwell-length input.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 8: idle cycles after each delay load before errors are counted.
REQ-005 SHALL have parameter READY_TIMEOUT, default 1024: maximum cycles to wait for delay_ready.
REQ-006 SHALL have ports as listed; one clock; reset is asynchronous and active-high.
- clk160  in  1  scan clock; all logic on its rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pulse; begins a scan of the masked links.
- abort  in  1  stops an active scan.
- link_mask  in  NLINKS  links to scan; sampled on accepted start.
- dwell_cycles  in  DWELL_WIDTH  error-count cycles per tap; sampled on accepted start; 0 is treated as 1.
- err_in  in  NLINKS  per-cycle P/N mismatch flag, one bit per link.
- delay_ready  in  NLINKS  delay element has applied its last load.
- delay_set  out  NLINKS  one-cycle one-hot load strobe.
- delay_value  out  DELAY_WIDTH  tap to load; valid while delay_set is high.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at scan end.
- cur_link  out  $clog2(NLINKS)  link being scanned.
- eye_width  out  NLINKS*(DELAY_WIDTH+1)  longest contiguous clean-tap run, per link.
- eye_center  out  NLINKS*DELAY_WIDTH  applied center tap, per link.
- eye_valid  out  NLINKS  result holds a nonzero eye.
- scan_error  out  NLINKS  no clean tap, or delay_ready timeout.

Function
REQ-007 FSM states SHALL be IDLE, SELECT, LOAD, WAIT_RDY, SETTLE, DWELL, EVAL, APPLY, APPLY_WAIT, NEXT.
REQ-008 IDLE: on start, sample link_mask and dwell_cycles, then go to SELECT.
- start with link_mask==0: done pulses on the next cycle; busy stays 0.
- start while busy: ignored.
REQ-009 SELECT: pick the lowest-index set mask bit at or above the link pointer, then go to LOAD with tap=0 and run/best trackers cleared.
- If no such bit exists, pulse done and return to IDLE.
REQ-010 LOAD: assert delay_set[cur_link] for exactly 1 cycle with delay_value=tap, then go to WAIT_RDY.
REQ-011 WAIT_RDY: advance to SETTLE when delay_ready[cur_link]=1.
- After READY_TIMEOUT cycles without ready: set scan_error[cur_link], clear eye_valid[cur_link], go to NEXT.
REQ-012 SETTLE: hold for exactly SETTLE_CYCLES cycles, then go to DWELL.
REQ-013 DWELL: run for max(dwell_cycles,1) cycles; the tap is dirty if err_in[cur_link] is 1 on any of them.
REQ-014 EVAL, clean tap: run_len increments; run_start=tap when run_len was 0.
- If run_len exceeds best_len (strict >, so ties keep the lower run), copy run_len/run_start into best_len/best_start.
REQ-015 EVAL, dirty tap: run_len is cleared.
REQ-016 EVAL, next state: if tap==2^DELAY_WIDTH-1 go to APPLY; otherwise tap+1 and go to LOAD.
- Runs SHALL NOT wrap from the max tap back to tap 0.
REQ-017 APPLY, best_len>0: center = best_start + floor((best_len-1)/2).
- Load center via a one-cycle delay_set, wait for ready (timeout as REQ-011) in APPLY_WAIT.
- Then write eye_width=best_len, eye_center=center, eye_valid=1, scan_error=0.
REQ-018 APPLY, best_len==0: write eye_width=0, eye_center=0, eye_valid=0, scan_error=1; no delay load.
REQ-019 NEXT: link pointer = cur_link+1, then go to SELECT.
REQ-020 Abort in any non-IDLE state: go to IDLE on the next edge with no done pulse.
- The current link's results are unchanged; a delay_set already issued is not retracted.
REQ-021 busy SHALL be 1 in every state except IDLE; the cycle-count from start to busy is 1.
REQ-022 Full-width eye: all taps clean gives eye_width=2^DELAY_WIDTH (needs the extra bit) and center=2^(DELAY_WIDTH-1)-1.

Reset
REQ-023 While rst=1, all outputs SHALL be 0, the FSM SHALL be IDLE, and every counter and tracker SHALL be 0.
REQ-024 rst asserted mid-scan SHALL discard all stored results; no done pulse follows.

Structure
REQ-025 Package link_eye_scanner_pkg SHALL hold the state enum typedef and the center-computation function.
REQ-026 Sub-module eye_run_tracker SHALL hold the run_len/run_start/best_len/best_start logic.
- It has clear, clean-tap strobe and dirty-tap strobe inputs.

Verification (bench: NLINKS=4, DELAY_WIDTH=4, SETTLE_CYCLES=2, delay_ready tied 1 unless stated)
REQ-027 Mask 0b0001, err_in[0] high on taps 0-3 and 11-15 -> eye_width[0]=7, eye_center[0]=7, eye_valid[0]=1, one done pulse.
REQ-028 Mask 0b0010, clean taps 2-4 and 9-11 (tie) -> eye_width=3, eye_center=3; the lower run wins.
REQ-029 Mask 0b0100, err_in[2] constantly 1 -> scan_error[2]=1, eye_valid[2]=0, no final delay_set.
- Mask 0b1000, all taps clean -> eye_width[3]=16, eye_center[3]=7.
REQ-030 Mask 0b1010, delay_ready[1] held 0 -> scan_error[1] after READY_TIMEOUT cycles; link 3 then scanned normally.
- Links are processed in order 1 then 3.
REQ-031 Mask 0b0001, abort at tap 5 -> busy drops, no done, prior results kept.
- rst mid-scan -> all outputs 0.
- start with mask 0 -> done next cycle.

Source files
------------

// File: rtl/link_eye_scanner_pkg.sv
// Shared types and helpers for the link eye scanner: FSM state encoding and
// the eye-center arithmetic.
package link_eye_scanner_pkg;

   typedef enum logic [3:0] {
      IDLE,
      SELECT,
      LOAD,
      WAIT_RDY,
      SETTLE,
      DWELL,
      EVAL,
      APPLY,
      APPLY_WAIT,
      NEXT
   } scan_state_e;

   // Center of a run; even-length runs round toward the lower tap.
   function automatic int unsigned eye_center_calc(input int unsigned best_start,
                                                   input int unsigned best_len);
      if (best_len == 0) return 0;
      return best_start + (best_len - 1) / 2;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/link_eye_scanner_run_tracker.sv
// Tracks the current and the longest contiguous run of clean taps during a
// single link's sweep; ties keep the earlier (lower-tap) run.
module eye_run_tracker
   import link_eye_scanner_pkg::*;
#(
   parameter int DELAY_WIDTH = 9
) (
   input  logic                   clk160,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   clean_stb,
   input  logic                   dirty_stb,
   input  logic [DELAY_WIDTH-1:0] tap,
   output logic [DELAY_WIDTH:0]   best_len,
   output logic [DELAY_WIDTH-1:0] best_start
);

   logic [DELAY_WIDTH:0]   run_len_q, run_len_d;
   logic [DELAY_WIDTH:0]   best_len_q, best_len_d;
   logic [DELAY_WIDTH-1:0] run_start_q, run_start_d;
   logic [DELAY_WIDTH-1:0] best_start_q, best_start_d;

   always_comb begin
      run_len_d    = run_len_q;
      run_start_d  = run_start_q;
      best_len_d   = best_len_q;
      best_start_d = best_start_q;
      if (clear) begin
         run_len_d    = '0;
         run_start_d  = '0;
         best_len_d   = '0;
         best_start_d = '0;
      end else if (clean_stb) begin
         run_len_d   = run_len_q + 1'b1;
         run_start_d = (run_len_q == '0) ? tap : run_start_q;
         if (run_len_d > best_len_q) begin
            best_len_d   = run_len_d;
            best_start_d = run_start_d;
         end
      end else if (dirty_stb) begin
         run_len_d = '0;
      end
   end

   always_ff @(posedge clk160 or posedge rst) begin
      if (rst) begin
         run_len_q    <= '0;
         run_start_q  <= '0;
         best_len_q   <= '0;
         best_start_q <= '0;
      end else begin
         run_len_q    <= run_len_d;
         run_start_q  <= run_start_d;
         best_len_q   <= best_len_d;
         best_start_q <= best_start_d;
      end
   end

   assign best_len   = best_len_q;
   assign best_start = best_start_q;

endmodule

// File: rtl/link_eye_scanner.sv
// Sweeps every delay tap of each selected link, finds the widest error-free
// window and parks the delay element in its center.
module link_eye_scanner
   import link_eye_scanner_pkg::*;
#(
   parameter int NLINKS        = 12,
   parameter int DELAY_WIDTH   = 9,
   parameter int DWELL_WIDTH   = 16,
   parameter int SETTLE_CYCLES = 8,
   parameter int READY_TIMEOUT = 1024
) (
   input  logic                              clk160,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              abort,
   input  logic [NLINKS-1:0]                 link_mask,
   input  logic [DWELL_WIDTH-1:0]            dwell_cycles,
   input  logic [NLINKS-1:0]                 err_in,
   input  logic [NLINKS-1:0]                 delay_ready,
   output logic [NLINKS-1:0]                 delay_set,
   output logic [DELAY_WIDTH-1:0]            delay_value,
   output logic                              busy,
   output logic                              done,
   output logic [$clog2(NLINKS)-1:0]         cur_link,
   output logic [NLINKS*(DELAY_WIDTH+1)-1:0] eye_width,
   output logic [NLINKS*DELAY_WIDTH-1:0]     eye_center,
   output logic [NLINKS-1:0]                 eye_valid,
   output logic [NLINKS-1:0]                 scan_error
);

   localparam int LW    = $clog2(NLINKS);
   localparam int PW    = $clog2(NLINKS + 1);
   localparam int CNT_W = max_int(max_int(DWELL_WIDTH, $clog2(READY_TIMEOUT + 1)),
                                  $clog2(SETTLE_CYCLES + 1)) + 1;
   localparam logic [CNT_W-1:0]       SETTLE_END = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0]       TMO_END    = CNT_W'(READY_TIMEOUT);
   localparam logic [DELAY_WIDTH-1:0] TAP_MAX    = '1;

   scan_state_e state_q, state_d;
   logic [NLINKS-1:0]      mask_q, mask_d;
   logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
   logic [PW-1:0]          ptr_q, ptr_d;
   logic [LW-1:0]          cur_q, cur_d;
   logic [DELAY_WIDTH-1:0] tap_q, tap_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   dirty_q, dirty_d;
   logic                   done_q, done_d;

   logic [DELAY_WIDTH:0]   width_q  [NLINKS];
   logic [DELAY_WIDTH:0]   width_d  [NLINKS];
   logic [DELAY_WIDTH-1:0] center_q [NLINKS];
   logic [DELAY_WIDTH-1:0] center_d [NLINKS];
   logic [NLINKS-1:0]      valid_q, valid_d;
   logic [NLINKS-1:0]      error_q, error_d;

   logic [CNT_W-1:0]       cnt_inc;
   logic [DWELL_WIDTH-1:0] dwell_len;
   logic [NLINKS-1:0]      onehot;
   logic                   sel_found;
   logic [LW-1:0]          sel_idx;
   logic                   trk_clear, clean_stb, dirty_stb;
   logic [DELAY_WIDTH:0]   best_len;
   logic [DELAY_WIDTH-1:0] best_start;
   logic [DELAY_WIDTH-1:0] center;

   assign cnt_inc   = cnt_q + 1'b1;
   assign dwell_len = (dwell_q == '0) ? DWELL_WIDTH'(1) : dwell_q;
   assign onehot    = NLINKS'(1) << cur_q;
   assign center    = DELAY_WIDTH'(eye_center_calc(32'(best_start), 32'(best_len)));

   eye_run_tracker #(
      .DELAY_WIDTH (DELAY_WIDTH)
   ) u_tracker (
      .clk160     (clk160),
      .rst        (rst),
      .clear      (trk_clear),
      .clean_stb  (clean_stb),
      .dirty_stb  (dirty_stb),
      .tap        (tap_q),
      .best_len   (best_len),
      .best_start (best_start)
   );

   // Descending loop so the lowest eligible link wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = NLINKS - 1; i >= 0; i--) begin
         if (mask_q[i] && (i >= int'(ptr_q))) begin
            sel_found = 1'b1;
            sel_idx   = LW'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      dwell_d     = dwell_q;
      ptr_d       = ptr_q;
      cur_d       = cur_q;
      tap_d       = tap_q;
      cnt_d       = '0;
      dirty_d     = 1'b0;
      done_d      = 1'b0;
      width_d     = width_q;
      center_d    = center_q;
      valid_d     = valid_q;
      error_d     = error_q;
      trk_clear   = 1'b0;
      clean_stb   = 1'b0;
      dirty_stb   = 1'b0;
      delay_set   = '0;
      delay_value = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (link_mask == '0) begin
                  done_d = 1'b1;
               end else begin
                  mask_d  = link_mask;
                  dwell_d = dwell_cycles;
                  ptr_d   = '0;
                  state_d = SELECT;
               end
            end
         end
         SELECT: begin
            trk_clear = 1'b1;
            if (sel_found) begin
               cur_d   = sel_idx;
               tap_d   = '0;
               state_d = LOAD;
            end else begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         LOAD: begin
            delay_set   = onehot;
            delay_value = tap_q;
            state_d     = WAIT_RDY;
         end
         WAIT_RDY: begin
            if (delay_ready[cur_q]) begin
               state_d = SETTLE;
            end else if (cnt_inc >= TMO_END) begin
               error_d[cur_q] = 1'b1;
               valid_d[cur_q] = 1'b0;
               state_d        = NEXT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         SETTLE: begin
            if (cnt_inc >= SETTLE_END) state_d = DWELL;
            else                       cnt_d   = cnt_inc;
         end
         DWELL: begin
            dirty_d = dirty_q | err_in[cur_q];
            if (cnt_inc >= CNT_W'(dwell_len)) state_d = EVAL;
            else                              cnt_d   = cnt_inc;
         end
         EVAL: begin
            clean_stb = ~dirty_q;
            dirty_stb = dirty_q;
            if (tap_q == TAP_MAX) begin
               state_d = APPLY;
            end else begin
               tap_d   = tap_q + 1'b1;
               state_d = LOAD;
            end
         end
         APPLY: begin
            if (best_len != '0) begin
               delay_set   = onehot;
               delay_value = center;
               state_d     = APPLY_WAIT;
            end else begin
               width_d[cur_q]  = '0;
               center_d[cur_q] = '0;
               valid_d[cur_q]  = 1'b0;
               error_d[cur_q]  = 1'b1;
               state_d         = NEXT;
            end
         end
         APPLY_WAIT: begin
            if (delay_ready[cur_q]) begin
               width_d[cur_q]  = best_len;
               center_d[cur_q] = center;
               valid_d[cur_q]  = 1'b1;
               error_d[cur_q]  = 1'b0;
               state_d         = NEXT;
            end else if (cnt_inc >= TMO_END) begin
               error_d[cur_q] = 1'b1;
               valid_d[cur_q] = 1'b0;
               state_d        = NEXT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         NEXT: begin
            ptr_d   = PW'(cur_q) + 1'b1;
            state_d = SELECT;
         end
         default: state_d = IDLE;
      endcase

      // Abort leaves results of the interrupted link untouched.
      if (abort && (state_q != IDLE)) begin
         state_d  = IDLE;
         done_d   = 1'b0;
         width_d  = width_q;
         center_d = center_q;
         valid_d  = valid_q;
         error_d  = error_q;
      end
   end

   always_ff @(posedge clk160 or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         mask_q   <= '0;
         dwell_q  <= '0;
         ptr_q    <= '0;
         cur_q    <= '0;
         tap_q    <= '0;
         cnt_q    <= '0;
         dirty_q  <= 1'b0;
         done_q   <= 1'b0;
         width_q  <= '{default: '0};
         center_q <= '{default: '0};
         valid_q  <= '0;
         error_q  <= '0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         dwell_q  <= dwell_d;
         ptr_q    <= ptr_d;
         cur_q    <= cur_d;
         tap_q    <= tap_d;
         cnt_q    <= cnt_d;
         dirty_q  <= dirty_d;
         done_q   <= done_d;
         width_q  <= width_d;
         center_q <= center_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign cur_link   = cur_q;
   assign eye_valid  = valid_q;
   assign scan_error = error_q;

   for (genvar g = 0; g < NLINKS; g++) begin : g_flat
      assign eye_width[g*(DELAY_WIDTH+1) +: DELAY_WIDTH+1] = width_q[g];
      assign eye_center[g*DELAY_WIDTH +: DELAY_WIDTH]      = center_q[g];
   end

endmodule
